// File: rtl/eth_test_checker.sv
// Ethernet test-traffic checker on the eth_axis receive path.
// Takes one header, then one payload frame, and checks MACs, ethertype,
// byte pattern, frame length and tuser. Results pass through one register
// stage before they reach the statistics counters and first-error capture.
module eth_test_checker #(
  parameter int          DATA_WIDTH  = 8,
  parameter bit          KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int          KEEP_WIDTH  = (DATA_WIDTH / 8),
  parameter logic [47:0] LOCAL_MAC   = 48'h02_00_00_00_00_00,
  parameter logic [47:0] DST_MAC     = 48'h02_00_00_00_00_00,
  parameter logic [15:0] ETH_TYPE    = 16'h88B5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_eth_hdr_valid,
  output logic                  s_eth_hdr_ready,
  input  logic [47:0]           s_eth_dest_mac,
  input  logic [47:0]           s_eth_src_mac,
  input  logic [15:0]           s_eth_type,
  input  logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_eth_payload_axis_tkeep,
  input  logic                  s_eth_payload_axis_tvalid,
  output logic                  s_eth_payload_axis_tready,
  input  logic                  s_eth_payload_axis_tlast,
  input  logic                  s_eth_payload_axis_tuser,
  input  logic [15:0]           cfg_length,
  input  logic                  cfg_mode,
  input  logic [3:0]            cfg_throttle,
  input  logic                  stat_clear,
  output logic [31:0]           frame_count,
  output logic [31:0]           byte_count,
  output logic [31:0]           hdr_err_count,
  output logic [31:0]           data_err_count,
  output logic [31:0]           len_err_count,
  output logic [31:0]           user_err_count,
  output logic                  first_err_valid,
  output logic [31:0]           first_err_frame,
  output logic [15:0]           first_err_offset
);

  typedef enum logic {IDLE, PAYLOAD} state_t;

  localparam logic [KEEP_WIDTH-1:0] KEEP_ONE = KEEP_WIDTH'(1);

  state_t      state;
  logic [31:0] seq;
  logic [15:0] len_q;
  logic [7:0]  start_q;
  logic [3:0]  thr_q;
  logic [3:0]  thr_cnt;
  logic [15:0] off_q;

  logic                  hdr_fire;
  logic                  pay_fire;
  logic [KEEP_WIDTH-1:0] keep_eff;
  logic [15:0]           pop;
  logic [7:0]            exp_byte;
  logic                  beat_bad;
  logic [16:0]           sum;
  logic                  sat;
  logic [15:0]           new_off;
  logic                  len_bad;
  logic                  hdr_bad;
  logic [3:0]            thr_nxt;

  // Registered compare results, one cycle behind the causing fire
  logic        p_beat;
  logic        p_last;
  logic [15:0] p_bytes;
  logic        p_hdr_bad;
  logic        p_data_bad;
  logic        p_len_bad;
  logic        p_user_bad;
  logic [15:0] p_offset;

  assign hdr_fire = s_eth_hdr_valid & s_eth_hdr_ready;
  assign pay_fire = s_eth_payload_axis_tvalid & s_eth_payload_axis_tready;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  // Per-beat pattern/keep check, running offset, length and header compares
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    keep_eff = KEEP_ENABLE ? s_eth_payload_axis_tkeep : '1;
    pop      = '0;
    exp_byte = '0;
    beat_bad = 1'b0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      exp_byte = start_q + off_q[7:0] + 8'(i);
      if (keep_eff[i]) begin
        pop = pop + 16'd1;
        if (s_eth_payload_axis_tdata[8*i +: 8] != exp_byte) beat_bad = 1'b1;
      end
    end
    // Valid bytes must be packed from the LSB; only the final beat may be short
    if ((keep_eff & (keep_eff + KEEP_ONE)) != '0) beat_bad = 1'b1;
    if (!s_eth_payload_axis_tlast && (keep_eff != {KEEP_WIDTH{1'b1}})) beat_bad = 1'b1;
    sum     = {1'b0, off_q} + {1'b0, pop};
    sat     = (sum >= 17'h0FFFF);
    new_off = sat ? 16'hFFFF : sum[15:0];
    len_bad = sat || (new_off != len_q) || (len_q == 16'd0);
    hdr_bad = (s_eth_dest_mac != LOCAL_MAC) || (s_eth_src_mac != DST_MAC) ||
              (s_eth_type != ETH_TYPE);
    thr_nxt = (thr_cnt == thr_q) ? 4'd0 : thr_cnt + 4'd1;
  end

  // Frame FSM with registered readies, frame config latch and byte offset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                     <= IDLE;
      s_eth_hdr_ready           <= 1'b0;
      s_eth_payload_axis_tready <= 1'b0;
      seq                       <= '0;
      len_q                     <= '0;
      start_q                   <= '0;
      thr_q                     <= '0;
      thr_cnt                   <= '0;
      off_q                     <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE: begin
          s_eth_payload_axis_tready <= 1'b0;
          if (hdr_fire) begin
            state                     <= PAYLOAD;
            s_eth_hdr_ready           <= 1'b0;
            s_eth_payload_axis_tready <= 1'b1;
            len_q                     <= cfg_length;
            start_q                   <= cfg_mode ? seq[7:0] : 8'h00;
            thr_q                     <= cfg_throttle;
            thr_cnt                   <= '0;
            off_q                     <= '0;
          end else begin
            s_eth_hdr_ready <= 1'b1;
          end
        end
        PAYLOAD: begin
          if (pay_fire) off_q <= new_off;
          if (pay_fire && s_eth_payload_axis_tlast) begin
            state                     <= IDLE;
            s_eth_hdr_ready           <= 1'b1;
            s_eth_payload_axis_tready <= 1'b0;
            seq                       <= seq + 32'd1;
          end else begin
            thr_cnt                   <= thr_nxt;
            s_eth_payload_axis_tready <= !((thr_nxt == thr_q) && (thr_q != 4'd0));
          end
        end
      endcase
    end
  end

  // Compare stage: capture results of each fire; a clear drops them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_beat     <= 1'b0;
      p_last     <= 1'b0;
      p_bytes    <= '0;
      p_hdr_bad  <= 1'b0;
      p_data_bad <= 1'b0;
      p_len_bad  <= 1'b0;
      p_user_bad <= 1'b0;
      p_offset   <= '0;
    end else begin
      p_beat     <= 1'b0;
      p_last     <= 1'b0;
      p_hdr_bad  <= 1'b0;
      p_data_bad <= 1'b0;
      p_len_bad  <= 1'b0;
      p_user_bad <= 1'b0;
      if (!stat_clear) begin
        if (hdr_fire) begin
          p_hdr_bad <= hdr_bad;
          p_offset  <= '0;
        end
        if (pay_fire) begin
          p_beat     <= 1'b1;
          p_last     <= s_eth_payload_axis_tlast;
          p_bytes    <= pop;
          p_data_bad <= beat_bad;
          p_len_bad  <= s_eth_payload_axis_tlast && len_bad;
          p_user_bad <= s_eth_payload_axis_tlast && s_eth_payload_axis_tuser;
          p_offset   <= off_q;
        end
      end
    end
  end

  // Statistics and first-error capture; clear wins over pending increments
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count      <= '0;
      byte_count       <= '0;
      hdr_err_count    <= '0;
      data_err_count   <= '0;
      len_err_count    <= '0;
      user_err_count   <= '0;
      first_err_valid  <= 1'b0;
      first_err_frame  <= '0;
      first_err_offset <= '0;
    end else if (stat_clear) begin
      frame_count      <= '0;
      byte_count       <= '0;
      hdr_err_count    <= '0;
      data_err_count   <= '0;
      len_err_count    <= '0;
      user_err_count   <= '0;
      first_err_valid  <= 1'b0;
      first_err_frame  <= '0;
      first_err_offset <= '0;
    end else begin
      if (p_beat) byte_count <= byte_count + {16'd0, p_bytes};
      if (p_beat && p_last) frame_count <= frame_count + 32'd1;
      if (p_hdr_bad)  hdr_err_count  <= sat_inc(hdr_err_count);
      if (p_data_bad) data_err_count <= sat_inc(data_err_count);
      if (p_len_bad)  len_err_count  <= sat_inc(len_err_count);
      if (p_user_bad) user_err_count <= sat_inc(user_err_count);
      if (!first_err_valid && (p_hdr_bad || p_data_bad || p_len_bad || p_user_bad)) begin
        first_err_valid  <= 1'b1;
        first_err_frame  <= frame_count;
        first_err_offset <= p_offset;
      end
    end
  end

endmodule

// File: doc/eth_test_checker.md
Name: eth_test_checker

Overview:
- Parametrised Ethernet test-traffic checker on the eth_axis receive path, downstream of the eth frame parser.
- Accepts one header, then one payload frame at a time, over DATA_WIDTH with tkeep.
- Checks MACs, ethertype, byte pattern (two modes), frame length and tuser.
- Keeps statistics and first-error capture, and can throttle tready to exercise upstream backpressure.

Parameters:
- DATA_WIDTH, 8, payload width in bits; multiple of 8, 8..64.
- KEEP_ENABLE, (DATA_WIDTH>8), tkeep used; if 0, tkeep is treated as all ones.
- KEEP_WIDTH, (DATA_WIDTH/8), bytes per beat.
- LOCAL_MAC, 48'h02_00_00_00_00_00, expected dest MAC.
- DST_MAC, 48'h02_00_00_00_00_00, expected src MAC.
- ETH_TYPE, 16'h88B5, expected ethertype.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- s_eth_hdr_valid/s_eth_hdr_ready  in/out  1  header handshake
- s_eth_dest_mac, s_eth_src_mac  input  48  header MACs
- s_eth_type  input  16  ethertype
- s_eth_payload_axis_tdata  input  DATA_WIDTH  payload; byte i = tdata[8i+7:8i]
- s_eth_payload_axis_tkeep  input  KEEP_WIDTH  byte enables
- s_eth_payload_axis_tvalid/tready  in/out  1  payload handshake
- s_eth_payload_axis_tlast, s_eth_payload_axis_tuser  input  1  end of frame / bad frame
- cfg_length  input  16  expected payload bytes per frame
- cfg_mode  input  1  0 = pattern starts at 0; 1 = pattern starts at frame sequence[7:0]
- cfg_throttle  input  4  0 = no throttle; N = tready low 1 cycle in every N+1
- stat_clear  input  1  synchronous clear of statistics and first-error capture
- frame_count, byte_count  output  32  frames / payload bytes accepted; wrap
- hdr_err_count, data_err_count, len_err_count, user_err_count  output  32  error counts; saturate at all-ones
- first_err_valid  output  1  first error captured
- first_err_frame  output  32  frame_count value at the first error
- first_err_offset  output  16  byte offset of the first bad beat

Behaviour:
- Reset (rst_n low, async):
  - State = IDLE; all counters, sequence number, throttle counter and first_err_* = 0.
  - Both readies = 0 (registered). hdr_ready = 1 on the first clk edge after release.
- FSM:
  - IDLE: hdr_ready = 1, payload tready = 0.
  - On hdr fire, latch cfg_length, cfg_mode and start byte (mode 0: 8'h00; mode 1: seq[7:0]), then go to PAYLOAD. hdr_ready drops the next cycle.
  - PAYLOAD: hdr_ready = 0; tready = 1 unless throttled.
  - On a payload fire with tlast, return to IDLE. hdr_ready = 1 the next cycle. seq increments and wraps at 2^32.
- Throttle:
  - 4-bit counter advances every cycle in PAYLOAD and wraps at cfg_throttle.
  - tready = 0 when the counter equals cfg_throttle and cfg_throttle != 0.
- Byte offset (16 bits) resets at hdr fire and advances by popcount(tkeep) per fire. It saturates at 16'hFFFF; reaching saturation forces len error at tlast.
- Data check: valid byte i expects (start + offset + i) mod 256. A beat is bad if any valid byte mismatches, or if tkeep is non-contiguous-from-LSB on any beat. On a non-tlast beat, tkeep != all ones is also bad.
- Error counting per frame:
  - data_err: +1 per bad beat.
  - hdr_err: +1 on hdr fire when dest MAC, src MAC or type differs; the payload is still checked.
  - len_err: +1 at tlast if total bytes != latched length.
  - user_err: +1 at tlast with tuser = 1.
- Pipeline:
  - Compares are registered. All counters and capture update exactly 1 cycle after the causing fire.
  - byte_count and frame_count also update 1 cycle after the fire; frame_count counts tlast fires.
  - Multiple error types in the same beat each increment their own counter.
- First-error capture: on the first error of any type while first_err_valid = 0, latch frame_count (pre-increment) and the beat's starting offset (0 for header errors). Set valid; hold until stat_clear or reset.
- stat_clear:
  - Zeroes statistics and capture, and takes priority over a same-cycle pending increment.
  - Does not affect the FSM, seq or an in-flight frame.
- cfg_length = 0: every frame is a length error.
- Inputs changed mid-frame take effect at the next header.

Test Plan:
- Reset, DATA_WIDTH=8, mode 0, length 64: 3 good frames -> frame_count=3, byte_count=192, all err counts 0, first_err_valid=0.
- DATA_WIDTH=32, length 62, last tkeep=4'b0011 -> no errors. Last tkeep=4'b0111 -> len_err_count=1, first_err_offset=60.
- Mode 1: send frames with start bytes 0, 1, 3 (frame 2 dropped upstream) -> data_err_count>=1, first_err_frame=2.
- Header src MAC wrong and tuser=1 on a good-pattern frame -> hdr_err_count=1, user_err_count=1, data_err_count=0, first_err_offset=0.
- cfg_throttle=3, upstream tvalid held 1 -> tready low exactly every 4th PAYLOAD cycle, all data accepted in order, zero errors.
- rst_n asserted mid-frame then released -> readies 0 during reset, next frame checked cleanly. stat_clear coincident with an error beat -> counters read 0.
